frame_capture_ctrl: RTL

Sequences the capture of one processed frame from a filter output stream (vsync/href/8-bit gray) into a BMP-ordered pixel buffer. Counts frames after a start command, opens a capture window on the selected frame, and generates buffer write strobes and byte addresses with BMP row padding. Flags completion or framing errors. Sits between a filter output (e.g. `median_filter`) and the bench/frame-buffer write port.

---
 rtl/frame_capture_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl: captures one selected frame from a vsync/href/gray
// stream and turns it into BMP-ordered write strobes and byte addresses.
// Each row starts at a multiple of the padded stride S = (width*3+3) & ~3.
// Optional feature: define CAP_LINE_CHECK_EN to flag a line whose length
// differs from img_width as an error (err=2).
module frame_capture_ctrl #(
  parameter int unsigned AW    = 32,
  parameter int unsigned DIM_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       frame_sel,
  input  logic [DIM_W-1:0] img_width,
  input  logic [DIM_W-1:0] img_height,
  input  logic             in_vsync,
  input  logic             in_href,
  input  logic [7:0]       in_data,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [23:0]      wr_data,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CAPTURE,
    S_DONE,
    S_ERROR
  } state_e;

  state_e           state_q;
  logic             vs_q, hs_q;
  logic [3:0]       sel_q, fcnt_q;
  logic [DIM_W-1:0] width_q, height_q, pix_q, line_q;
  logic [AW-1:0]    stride_q, base_q, off_q;
  logic             wr_en_q, busy_q, done_q;
  logic [AW-1:0]    wr_addr_q;
  logic [23:0]      wr_data_q;
  logic [1:0]       err_q;

  logic             vs_rise, hs_fall, line_last, line_bad, can_start;
  logic             cap_active, pix_wr;
  logic [AW-1:0]    stride_d;

  // Edge detects, start qualification, stride setup and pixel-write decode
  always_comb begin
    vs_rise   = in_vsync & ~vs_q;
    hs_fall   = ~in_href & hs_q;
    line_last = (line_q + DIM_W'(1)) == height_q;
`ifdef CAP_LINE_CHECK_EN
    line_bad  = pix_q != width_q;
`else
    line_bad  = 1'b0;
`endif
    can_start = start & ((state_q == S_IDLE) | (state_q == S_DONE) |
                         (state_q == S_ERROR));
    stride_d  = ((AW'(img_width) * AW'(3)) + AW'(3)) & ~AW'(3);
    // The vsync edge that selects the frame already captures a pixel
    // presented in that same cycle; counters are still cleared from start.
    cap_active = (state_q == S_CAPTURE) |
                 ((state_q == S_WAIT) & vs_rise & (fcnt_q == sel_q));
    pix_wr     = cap_active & in_href & (pix_q < width_q);
  end

  // Capture FSM, address counters and registered write-port outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      vs_q      <= 1'b0;
      hs_q      <= 1'b0;
      sel_q     <= '0;
      fcnt_q    <= '0;
      width_q   <= '0;
      height_q  <= '0;
      pix_q     <= '0;
      line_q    <= '0;
      stride_q  <= '0;
      base_q    <= '0;
      off_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= '0;
    end else begin
      vs_q    <= in_vsync;
      hs_q    <= in_href;
      wr_en_q <= pix_wr;
      if (pix_wr) begin
        wr_addr_q <= base_q + off_q;
        wr_data_q <= {3{in_data}};
        off_q     <= off_q + AW'(3);
      end
      // Pixel count includes dropped pixels so the optional length check
      // sees the true line length; it saturates instead of wrapping.
      if (cap_active && in_href && (pix_q != '1)) begin
        pix_q <= pix_q + DIM_W'(1);
      end

      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (can_start) begin
            state_q  <= S_WAIT;
            sel_q    <= frame_sel;
            width_q  <= img_width;
            height_q <= img_height;
            stride_q <= stride_d;
            fcnt_q   <= '0;
            pix_q    <= '0;
            line_q   <= '0;
            base_q   <= '0;
            off_q    <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= '0;
          end
        end
        S_WAIT: begin
          if (vs_rise) begin
            fcnt_q <= fcnt_q + 4'd1;
            if (fcnt_q == sel_q) begin
              state_q <= S_CAPTURE;
            end
          end
        end
        S_CAPTURE: begin
          if (hs_fall) begin
            if (line_bad) begin
              state_q <= S_ERROR;
              busy_q  <= 1'b0;
              err_q   <= 2'd2;
            end else begin
              // Line completion is resolved before a coincident vsync edge.
              line_q <= line_q + DIM_W'(1);
              pix_q  <= '0;
              off_q  <= '0;
              base_q <= base_q + stride_q;
              if (line_last) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else if (vs_rise) begin
                state_q <= S_ERROR;
                busy_q  <= 1'b0;
                err_q   <= 2'd1;
              end
            end
          end else if (vs_rise) begin
            state_q <= S_ERROR;
            busy_q  <= 1'b0;
            err_q   <= 2'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule
